hll_dma_write_packer: RTL

// Sits directly downstream of hyperloglog_ip. Consumes its write-command

---
 rtl/hll_dma_write_packer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/hll_dma_write_packer.sv
// Bridges the hyperloglog_ip write-command and 32-bit data streams onto a
// 512-bit DMA write port: one DMA command per input command, 16 words per beat.
module hll_dma_write_packer #(
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 32,
  parameter int IN_W   = 32,
  parameter int OUT_W  = 512
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    s_cmd_valid,
  output logic                    s_cmd_ready,
  input  logic [ADDR_W+LEN_W-1:0] s_cmd_data,
  input  logic                    s_data_valid,
  output logic                    s_data_ready,
  input  logic [IN_W-1:0]         s_data_data,
  input  logic [IN_W/8-1:0]       s_data_keep,
  input  logic                    s_data_last,
  output logic                    m_cmd_valid,
  input  logic                    m_cmd_ready,
  output logic [ADDR_W-1:0]       m_cmd_address,
  output logic [LEN_W-1:0]        m_cmd_length,
  output logic                    m_data_valid,
  input  logic                    m_data_ready,
  output logic [OUT_W-1:0]        m_data_data,
  output logic [OUT_W/8-1:0]      m_data_keep,
  output logic                    m_data_last,
  output logic [31:0]             status_cmd_cnt,
  output logic                    status_len_err
);

  localparam int NW    = OUT_W / IN_W;
  localparam int KW    = IN_W / 8;
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_PACK  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  function automatic logic [LEN_W-1:0] popcount(input logic [KW-1:0] keep);
    logic [LEN_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < KW; i++) begin
      cnt = cnt + {{(LEN_W-1){1'b0}}, keep[i]};
    end
    return cnt;
  endfunction

  state_t                     state_r;
  logic                       cmd_rdy_r;
  logic                       pack_r;
  logic                       m_cmd_valid_r;
  logic [ADDR_W-1:0]          addr_r;
  logic [LEN_W-1:0]           len_r;
  logic [LEN_W-1:0]           bytes_r;
  logic [31:0]                cnt_r;
  logic                       len_err_r;

  logic [NW-1:0][IN_W-1:0]    buf_data_r;
  logic [NW-1:0][KW-1:0]      buf_keep_r;
  logic [IDX_W-1:0]           idx_r;
  logic [NW-1:0][IN_W-1:0]    out_data_r;
  logic [NW-1:0][KW-1:0]      out_keep_r;
  logic                       out_valid_r;
  logic                       out_last_r;

  logic                       cmd_acc_s;
  logic [ADDR_W-1:0]          cmd_addr_s;
  logic [LEN_W-1:0]           cmd_len_s;
  logic                       s_data_ready_s;
  logic                       data_acc_s;
  logic                       flush_s;
  logic [LEN_W-1:0]           bytes_next_s;
  logic [NW-1:0][IN_W-1:0]    merged_data_s;
  logic [NW-1:0][KW-1:0]      merged_keep_s;

  assign cmd_addr_s = s_cmd_data[ADDR_W-1:0];
  assign cmd_len_s  = s_cmd_data[ADDR_W +: LEN_W];
  assign cmd_acc_s  = s_cmd_valid & cmd_rdy_r;

  // Input stalls only while a full beat is waiting on a blocked DMA port.
  assign s_data_ready_s = pack_r & ~(out_valid_r & ~m_data_ready);
  assign data_acc_s     = s_data_valid & s_data_ready_s;
  assign flush_s        = data_acc_s & (s_data_last | (idx_r == IDX_W'(NW-1)));

  // Pack buffer with the incoming word placed in the current lane, plus byte tally
  always_comb begin
    merged_data_s        = buf_data_r;
    merged_keep_s        = buf_keep_r;
    merged_data_s[idx_r] = s_data_data;
    merged_keep_s[idx_r] = s_data_keep;
    bytes_next_s         = bytes_r + popcount(s_data_keep);
  end

  // Command FSM: command capture, DMA command issue, length check and status
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r       <= ST_IDLE;
      cmd_rdy_r     <= 1'b0;
      pack_r        <= 1'b0;
      m_cmd_valid_r <= 1'b0;
      addr_r        <= '0;
      len_r         <= '0;
      bytes_r       <= '0;
      cnt_r         <= 32'd0;
      len_err_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_acc_s) begin
            if (cmd_len_s == '0) begin
              len_err_r <= 1'b1;
            end else begin
              addr_r        <= cmd_addr_s;
              len_r         <= cmd_len_s;
              m_cmd_valid_r <= 1'b1;
              cmd_rdy_r     <= 1'b0;
              state_r       <= ST_CMD;
            end
          end else begin
            cmd_rdy_r <= 1'b1;
          end
        end
        ST_CMD: begin
          if (m_cmd_ready) begin
            m_cmd_valid_r <= 1'b0;
            cnt_r         <= cnt_r + 32'd1;
            pack_r        <= 1'b1;
            state_r       <= ST_PACK;
          end else begin
            m_cmd_valid_r <= 1'b1;
          end
        end
        ST_PACK: begin
          if (data_acc_s) begin
            bytes_r <= bytes_next_s;
            if (s_data_last) begin
              pack_r  <= 1'b0;
              state_r <= ST_DRAIN;
              if (bytes_next_s != len_r) begin
                len_err_r <= 1'b1;
              end else begin
                len_err_r <= len_err_r;
              end
            end else begin
              pack_r <= 1'b1;
            end
          end else begin
            pack_r <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (out_valid_r && m_data_ready) begin
            bytes_r   <= '0;
            cmd_rdy_r <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            cmd_rdy_r <= 1'b0;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          cmd_rdy_r     <= 1'b0;
          pack_r        <= 1'b0;
          m_cmd_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Lane packing and the AXIS-stable output beat register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_data_r  <= '0;
      buf_keep_r  <= '0;
      idx_r       <= '0;
      out_data_r  <= '0;
      out_keep_r  <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      if (data_acc_s) begin
        if (flush_s) begin
          // Cleared buffer guarantees unwritten lanes leave as data=0, keep=0.
          buf_data_r <= '0;
          buf_keep_r <= '0;
          idx_r      <= '0;
        end else begin
          buf_data_r <= merged_data_s;
          buf_keep_r <= merged_keep_s;
          idx_r      <= idx_r + IDX_W'(1);
        end
      end
      if (flush_s) begin
        out_data_r  <= merged_data_s;
        out_keep_r  <= merged_keep_s;
        out_last_r  <= s_data_last;
        out_valid_r <= 1'b1;
      end else if (m_data_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign s_cmd_ready    = cmd_rdy_r;
  assign s_data_ready   = s_data_ready_s;
  assign m_cmd_valid    = m_cmd_valid_r;
  assign m_cmd_address  = addr_r;
  assign m_cmd_length   = len_r;
  assign m_data_valid   = out_valid_r;
  assign m_data_data    = out_data_r;
  assign m_data_keep    = out_keep_r;
  assign m_data_last    = out_last_r;
  assign status_cmd_cnt = cnt_r;
  assign status_len_err = len_err_r;

endmodule
